// File: rtl/uart_button_debounce.sv
// Per-channel 2-FF synchroniser and counter debouncer for push-buttons, with press/release strobes.
// Optional auto-repeat on btn_press when UART_BUTTON_DEBOUNCE_REPEAT_EN is defined.
module uart_button_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_stable,
  output logic [WIDTH-1:0] btn_pressed,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
  localparam int unsigned REP_W     = 32;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_q [WIDTH];
  logic [REP_W-1:0] rep_d [WIDTH];
  logic [WIDTH-1:0] first_q, first_d;
`endif

  // Next-state: debounce counters, accepted level, and strobes
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        if (s2_q[i] != ACTIVE_LOW) press_d[i]   = 1'b1;
        else                       release_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
    first_d = first_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rep_d[i] = rep_q[i];
      if (press_d[i]) begin
        rep_d[i]   = '0;
        first_d[i] = 1'b1;
      end else if ((stable_q[i] != ACTIVE_LOW) && (stable_d[i] != ACTIVE_LOW)) begin
        // Held: first re-pulse after the delay, then at the period
        if (rep_q[i] == (first_q[i] ? DELAY_LAST : PERIOD_LAST)) begin
          press_d[i] = 1'b1;
          rep_d[i]   = '0;
          first_d[i] = 1'b0;
        end else begin
          rep_d[i] = rep_q[i] + REP_W'(1);
        end
      end else begin
        rep_d[i]   = '0;
        first_d[i] = 1'b0;
      end
    end
`endif
  end

  // State registers with synchronous reset to the released level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= RELEASED;
      s2_q      <= RELEASED;
      stable_q  <= RELEASED;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '{default: '0};
`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
      rep_q     <= '{default: '0};
      first_q   <= '0;
`endif
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
      rep_q     <= rep_d;
      first_q   <= first_d;
`endif
    end
  end

  assign btn_stable  = stable_q;
  assign btn_pressed = stable_q ^ RELEASED;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_uart_button_debounce.sv
// Directed bench for uart_button_debounce with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, WIDTH=2.
module tb_uart_button_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_stable, btn_pressed, btn_press, btn_release;
  logic [5:0] obs, exp;
  int         ncmp = 0;
  int         nerr = 0;

  assign obs = {btn_stable, btn_press, btn_release};

  uart_button_debounce #(
    .WIDTH(2), .DEBOUNCE_CYCLES(4), .CNT_W(4), .ACTIVE_LOW(1'b1)
`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
    , .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
`endif
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_stable(btn_stable),
    .btn_pressed(btn_pressed), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_raw = 2'b11;
    tick(); tick();
    ncmp++;
    if (obs !== 6'b11_00_00) begin nerr++; $display("FAIL reset_state stb/prs/rel got %b want 110000", obs); end
    ncmp++;
    if (btn_pressed !== 2'b00) begin nerr++; $display("FAIL reset_pressed got %b want 00", btn_pressed); end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      ncmp++;
      if (obs !== 6'b11_00_00) begin nerr++; $display("FAIL post_reset_idle k=%0d got %b want 110000", k, obs); end
    end
  endtask

  task automatic test_press_release();
    btn_raw = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k == 6) ? 6'b10_01_00 : (k == 7) ? 6'b10_00_00 : 6'b11_00_00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL press_latency k=%0d got %b want %b", k, obs, exp); end
    end
    ncmp++;
    if (btn_pressed !== 2'b01) begin nerr++; $display("FAIL pressed_map got %b want 01", btn_pressed); end
    btn_raw = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k == 6) ? 6'b11_00_01 : (k == 7) ? 6'b11_00_00 : 6'b10_00_00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL release_latency k=%0d got %b want %b", k, obs, exp); end
    end
  endtask

  task automatic test_bounce();
    btn_raw = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      tick();
      ncmp++;
      if (obs !== 6'b11_00_00) begin nerr++; $display("FAIL bounce_low k=%0d got %b want 110000", k, obs); end
    end
    btn_raw = 2'b11;
    for (int k = 1; k <= 2; k++) begin
      tick();
      ncmp++;
      if (obs !== 6'b11_00_00) begin nerr++; $display("FAIL bounce_high k=%0d got %b want 110000", k, obs); end
    end
    btn_raw = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k == 6) ? 6'b10_01_00 : (k == 7) ? 6'b10_00_00 : 6'b11_00_00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL bounce_settle k=%0d got %b want %b", k, obs, exp); end
    end
    btn_raw = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 6) ? 6'b11_00_01 : 6'b10_00_00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL bounce_release k=%0d got %b want %b", k, obs, exp); end
    end
    tick();
  endtask

  task automatic test_both_channels();
    btn_raw = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 6) ? 6'b00_11_00 : 6'b11_00_00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL dual_press k=%0d got %b want %b", k, obs, exp); end
    end
    btn_raw = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 6) ? 6'b11_00_11 : 6'b00_00_00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL dual_release k=%0d got %b want %b", k, obs, exp); end
    end
    tick();
  endtask

  task automatic test_reset_mid_count();
    btn_raw = 2'b10;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    ncmp++;
    if (obs !== 6'b11_00_00) begin nerr++; $display("FAIL midcount_reset got %b want 110000", obs); end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k == 6) ? 6'b10_01_00 : (k == 7) ? 6'b10_00_00 : 6'b11_00_00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL midcount_restart k=%0d got %b want %b", k, obs, exp); end
    end
    btn_raw = 2'b11;
    for (int k = 1; k <= 7; k++) tick();
    ncmp++;
    if (obs !== 6'b11_00_00) begin nerr++; $display("FAIL midcount_idle got %b want 110000", obs); end
  endtask

`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
  task automatic test_repeat();
    btn_raw = 2'b01;
    for (int k = 1; k <= 6; k++) tick();
    ncmp++;
    if (obs !== 6'b01_10_00) begin nerr++; $display("FAIL repeat_t0 got %b want 011000", obs); end
    // Pin released after k=18; debounced release lands at k=24
    for (int k = 1; k <= 40; k++) begin
      if (k == 19) btn_raw = 2'b11;
      tick();
      exp[5:4] = (k < 24) ? 2'b01 : 2'b11;
      exp[3:2] = (k == 10 || k == 15 || k == 20) ? 2'b10 : 2'b00;
      exp[1:0] = (k == 24) ? 2'b10 : 2'b00;
      ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL repeat k=%0d got %b want %b", k, obs, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_both_channels();
    test_reset_mid_count();
`ifdef UART_BUTTON_DEBOUNCE_REPEAT_EN
    test_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
